// File: rtl/claw_credit_ctrl_if.sv
// Claw controller bus: coin/button strobes in, claw drive and payout out.
//   master : coin/button synchroniser side (drives strobes)
//   slave  : claw_credit_ctrl (drives claw, refund and credit outputs)
// Signals:
//   one, two, catch, refund : 1-cycle input strobes
//   strength [CW]           : claw strength, nonzero only while claw_busy
//   claw_busy               : claw motor drive active
//   grab_done               : 1-cycle pulse at grab completion
//   balance [CW]            : refunded amount, valid with refund_valid, else 0
//   refund_valid            : 1-cycle payout pulse
//   credit [CW]             : current accumulated credit
interface claw_credit_ctrl_if #(
  parameter int CW = 4
);
  logic          one;
  logic          two;
  logic          catch;
  logic          refund;
  logic [CW-1:0] strength;
  logic          claw_busy;
  logic          grab_done;
  logic [CW-1:0] balance;
  logic          refund_valid;
  logic [CW-1:0] credit;

  modport master (
    output one, two, catch, refund,
    input  strength, claw_busy, grab_done, balance, refund_valid, credit
  );

  modport slave (
    input  one, two, catch, refund,
    output strength, claw_busy, grab_done, balance, refund_valid, credit
  );
endinterface

// File: rtl/claw_credit_ctrl.sv
// claw_credit_ctrl: coin credit accumulator and timed claw grab sequencer.
// Coins of 1/2/3 units accumulate up to MAX_CREDIT; one unit more refunds
// everything. catch converts credit to claw strength and drives the claw for
// strength*GRAB_CYC cycles. Coins arriving mid-grab are refunded immediately.
// Optional macro CLAW_AUTO_REFUND_EN: refund held credit after TIMEOUT_CYC
// idle cycles.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous reset, active high
//   bus  : claw_credit_ctrl_if.slave (strobes in; claw/refund/credit out)
module claw_credit_ctrl #(
  parameter int MAX_CREDIT  = 9,
  parameter int GRAB_CYC    = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CW          = $clog2(MAX_CREDIT + 4)
) (
  input  logic            clk,
  input  logic            rstn,
  claw_credit_ctrl_if.slave bus
);

  // Wide enough for any CW-bit value times GRAB_CYC.
  localparam int GW = CW + $clog2(GRAB_CYC + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, CREDIT, GRAB} state_t;

  state_t        state;
  logic [CW-1:0] credit;
  logic [CW-1:0] strength;
  logic          claw_busy;
  logic          grab_done;
  logic [CW-1:0] balance;
  logic          refund_valid;
  logic [GW-1:0] gcnt;

`ifdef CLAW_AUTO_REFUND_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt;
`endif

  logic [CW-1:0] add;
  logic [CW-1:0] sum;

  // one + 2*two, never wraps since CW covers MAX_CREDIT+3
  assign add = {{(CW-2){1'b0}}, bus.two, bus.one};
  assign sum = credit + add;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state        <= IDLE;
      credit       <= '0;
      strength     <= '0;
      claw_busy    <= 1'b0;
      grab_done    <= 1'b0;
      balance      <= '0;
      refund_valid <= 1'b0;
      gcnt         <= '0;
`ifdef CLAW_AUTO_REFUND_EN
      tcnt         <= '0;
`endif
    end else begin
      grab_done    <= 1'b0;
      refund_valid <= 1'b0;
      balance      <= '0;
`ifdef CLAW_AUTO_REFUND_EN
      tcnt         <= '0;
`endif
      case (state)
        IDLE, CREDIT: begin
          if ((bus.refund && credit != '0) || sum > MAXC) begin
            // explicit refund or overflow: pay out everything incl. this coin
            balance      <= sum;
            refund_valid <= 1'b1;
            credit       <= '0;
            state        <= IDLE;
          end else if (bus.catch && sum != '0) begin
            strength  <= sum;
            claw_busy <= 1'b1;
            credit    <= '0;
            gcnt      <= GW'(sum) * GW'(GRAB_CYC);
            state     <= GRAB;
          end else if (add != '0) begin
            credit <= sum;
            state  <= CREDIT;
          end
`ifdef CLAW_AUTO_REFUND_EN
          // Reaching here in CREDIT means no strobe this cycle.
          else if (state == CREDIT) begin
            if (tcnt == TLAST) begin
              balance      <= credit;
              refund_valid <= 1'b1;
              credit       <= '0;
              state        <= IDLE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`endif
        end
        GRAB: begin
          // coins are bounced straight back; catch/refund ignored
          if (add != '0) begin
            balance      <= add;
            refund_valid <= 1'b1;
          end
          if (gcnt == GW'(1)) begin
            claw_busy <= 1'b0;
            strength  <= '0;
            grab_done <= 1'b1;
            state     <= IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.strength     = strength;
  assign bus.claw_busy    = claw_busy;
  assign bus.grab_done    = grab_done;
  assign bus.balance      = balance;
  assign bus.refund_valid = refund_valid;
  assign bus.credit       = credit;

endmodule

// File: tb/tb_claw_credit_ctrl.sv
module tb_claw_credit_ctrl;
  localparam int MAXC = 9;
  localparam int GC   = 2;
  localparam int TO   = 8;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  claw_credit_ctrl_if #(.CW(CW)) bus();

  claw_credit_ctrl #(.MAX_CREDIT(MAXC), .GRAB_CYC(GC), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {int st; int len;} grab_t;

  int    checks = 0;
  int    fails  = 0;
  int    rq[$];
  grab_t gq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name, input int act);
    fails++;
    $display("FAIL %s actual=%0d expected=none @%0t", name, act, $time);
  endtask

  // Monitor: pops expectations when the DUT presents refund/grab events.
  bit    in_grab = 1'b0;
  int    g_st, g_len;
  grab_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        in_grab = 1'b0;
      end else begin
        if (bus.refund_valid) begin
          if (rq.size() == 0) bad("unexpected_refund", int'(bus.balance));
          else chk("refund_balance", int'(bus.balance), rq.pop_front());
        end else if (bus.balance != '0) begin
          bad("balance_without_valid", int'(bus.balance));
        end
        if (bus.claw_busy) begin
          if (!in_grab) begin
            in_grab = 1'b1;
            g_st    = int'(bus.strength);
            g_len   = 1;
          end else begin
            g_len++;
            if (int'(bus.strength) != g_st) bad("strength_changed", int'(bus.strength));
          end
        end else if (bus.strength != '0) begin
          bad("strength_while_idle", int'(bus.strength));
        end
        if (bus.grab_done) begin
          if (gq.size() == 0) begin
            bad("unexpected_grab_done", g_st);
          end else begin
            e = gq.pop_front();
            chk("grab_strength", g_st, e.st);
            chk("grab_len", g_len, e.len);
          end
          in_grab = 1'b0;
        end
      end
    end
  end

  task automatic step(input bit o, input bit t, input bit c, input bit r);
    bus.one = o; bus.two = t; bus.catch = c; bus.refund = r;
    @(posedge clk);
    #1;
    bus.one = 1'b0; bus.two = 1'b0; bus.catch = 1'b0; bus.refund = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  initial begin
    bus.one = 1'b0; bus.two = 1'b0; bus.catch = 1'b0; bus.refund = 1'b0;
    rstn = 1'b0;
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_strength", int'(bus.strength), 0);
    chk("rst_busy", int'(bus.claw_busy), 0);
    chk("rst_done", int'(bus.grab_done), 0);
    chk("rst_refund_valid", int'(bus.refund_valid), 0);
    chk("rst_balance", int'(bus.balance), 0);
    rstn = 1'b0;
    idle(5);
    chk("idle_credit", int'(bus.credit), 0);
    chk("idle_strength", int'(bus.strength), 0);

    // ten single coins: 1..9 then overflow refund of 10
    for (int i = 1; i <= 9; i++) begin
      step(1, 0, 0, 0);
      chk("credit_count1", int'(bus.credit), i);
    end
    rq.push_back(10);
    step(1, 0, 0, 0);
    chk("ovf1_credit", int'(bus.credit), 0);

    // four triple coins: 3,6,9 then refund 12
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 0, 0);
      chk("credit_count3", int'(bus.credit), 3 * i);
    end
    rq.push_back(12);
    step(1, 1, 0, 0);
    chk("ovf3_credit", int'(bus.credit), 0);

    // grab of strength 3 -> 6 drive cycles
    repeat (3) step(1, 0, 0, 0);
    gq.push_back('{st: 3, len: 6});
    step(0, 0, 1, 0);
    chk("grab3_busy", int'(bus.claw_busy), 1);
    chk("grab3_credit", int'(bus.credit), 0);
    idle(8);
    chk("grab3_end_busy", int'(bus.claw_busy), 0);

    // grab of strength 4 -> 8 drive cycles
    repeat (2) step(0, 1, 0, 0);
    gq.push_back('{st: 4, len: 8});
    step(0, 0, 1, 0);
    idle(10);

    // coin and refund together: coin included
    step(0, 1, 0, 0);
    rq.push_back(3);
    step(1, 0, 0, 1);
    chk("coin_refund_credit", int'(bus.credit), 0);

    // catch+refund with credit 5: refund wins
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("credit5", int'(bus.credit), 5);
    rq.push_back(5);
    step(0, 0, 1, 1);
    chk("catch_refund_credit", int'(bus.credit), 0);
    chk("catch_refund_busy", int'(bus.claw_busy), 0);

    // refund/catch with zero credit are ignored
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("ignored_busy", int'(bus.claw_busy), 0);
    idle(2);

    // coin mid-grab bounced; grab length unchanged
    step(0, 1, 0, 0);
    gq.push_back('{st: 2, len: 4});
    step(0, 0, 1, 0);
    rq.push_back(2);
    step(0, 1, 0, 0);
    chk("midgrab_credit", int'(bus.credit), 0);
    idle(5);
    chk("after_grab_credit", int'(bus.credit), 0);

`ifdef CLAW_AUTO_REFUND_EN
    rq.push_back(1);
    step(1, 0, 0, 0);
    idle(8);
    chk("timeout1_credit", int'(bus.credit), 0);
    step(1, 0, 0, 0);
    idle(6);
    step(1, 0, 0, 0);
    chk("timeout_restart_credit", int'(bus.credit), 2);
    idle(7);
    chk("timeout_hold_credit", int'(bus.credit), 2);
    rq.push_back(2);
    idle(1);
    chk("timeout2_credit", int'(bus.credit), 0);
`else
    step(1, 0, 0, 0);
    idle(100);
    chk("no_timeout_credit", int'(bus.credit), 1);
    rq.push_back(1);
    step(0, 0, 0, 1);
    chk("manual_refund_credit", int'(bus.credit), 0);
`endif

    // reset mid-grab: drive drops immediately, no refund
    step(1, 0, 0, 0);
    gq.push_back('{st: 1, len: 2});
    step(0, 0, 1, 0);
    chk("pre_rst_busy", int'(bus.claw_busy), 1);
    rstn = 1'b1;
    #1;
    chk("rst_grab_busy", int'(bus.claw_busy), 0);
    chk("rst_grab_strength", int'(bus.strength), 0);
    chk("rst_grab_credit", int'(bus.credit), 0);
    gq.delete();
    @(posedge clk);
    #1 rstn = 1'b0;
    idle(4);

    chk("refund_queue_empty", rq.size(), 0);
    chk("grab_queue_empty", gq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
